// File: rtl/servo_pkg.sv
// Constants and types shared by the servo pulse generator and decoder.
// Both sides import these so the pulse encoding cannot drift apart.
package servo_pkg;

  localparam int unsigned M           = 94;
  localparam int unsigned OFFSET      = 46;
  localparam int unsigned FRAME_TICKS = 2048;

  typedef logic [7:0] pos_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus registered edge detect for async pins.
// Ports: clk, rst, din (async) -> level, rise, fall (one-cycle pulses).
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  // Synchronizer flops are not reset so a pin that is already high
  // still reads high right after reset.
  always_ff @(posedge clk) begin
    s1   <= din;
    s2   <= s1;
    prev <= s2;
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= s2 & ~prev;
      fall <= ~s2 & prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures RC/servo PWM high time and converts it to an 8-bit position.
// Ports: clk, rst, servo_in -> pos, valid (strobe), err (strobe), lost.
module servo_pulse_decoder #(
  parameter int unsigned M           = servo_pkg::M,
  parameter int unsigned OFFSET      = servo_pkg::OFFSET,
  parameter int unsigned FRAME_TICKS = servo_pkg::FRAME_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            servo_in,
  output servo_pkg::pos_t pos,
  output logic            valid,
  output logic            err,
  output logic            lost
);

  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned GW = $clog2(FRAME_TICKS);

  localparam logic [PW-1:0] P_TOP  = PW'(M - 1);
  localparam logic [PW-1:0] P_HALF = PW'(M / 2);
  localparam logic [GW-1:0] G_TOP  = GW'(FRAME_TICKS - 1);
  localparam logic [8:0]    W_TOP  = 9'd511;
  localparam logic [9:0]    W_LO   = 10'(OFFSET);
  localparam logic [9:0]    W_HI   = 10'(OFFSET + 255);

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARMED,
    HIGH
  } state_t;

  state_t          state;
  state_t          state_n;
  logic            level;
  logic            rise;
  logic            fall;
  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_n;
  logic [PW-1:0]   presc_inc;
  logic [8:0]      width;
  logic [8:0]      width_n;
  logic [8:0]      width_inc;
  logic [GW-1:0]   gap;
  logic [GW-1:0]   gap_n;
  logic            pend;
  logic            pend_n;
  servo_pkg::pos_t pos_n;
  logic            valid_n;
  logic            err_n;
  logic            lost_n;
  logic            tick;
  logic [9:0]      w;

  sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (servo_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign tick      = (presc == P_TOP);
  assign presc_inc = tick ? '0 : presc + 1'b1;
  assign width_inc = (tick && width != W_TOP) ? width + 1'b1 : width;

  // The fall cycle is still high time, so round on the counts that
  // include it.
  assign w = {1'b0, width_inc} + {9'd0, presc_inc >= P_HALF};

  always_comb begin
    state_n = state;
    presc_n = rise ? '0 : presc_inc;
    width_n = width;
    gap_n   = gap;
    pend_n  = pend;
    pos_n   = pos;
    valid_n = 1'b0;
    err_n   = 1'b0;
    lost_n  = lost;
    unique case (state)
      WAIT_LOW: begin
        if (!level) begin
          state_n = ARMED;
          err_n   = fall & pend;
          pend_n  = 1'b0;
        end
      end
      ARMED: begin
        if (rise) begin
          state_n = HIGH;
          width_n = '0;
        end
      end
      HIGH: begin
        width_n = width_inc;
        if (fall) begin
          state_n = ARMED;
          if (w >= W_LO && w <= W_HI) begin
            pos_n   = servo_pkg::pos_t'(w - W_LO);
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (width == W_TOP) begin
          // Overlong pulse: report it once when it finally ends.
          state_n = WAIT_LOW;
          pend_n  = 1'b1;
        end
      end
      default: state_n = WAIT_LOW;
    endcase
    if (rise) begin
      gap_n = '0;
    end else if (tick && state != HIGH && gap != G_TOP) begin
      gap_n = gap + 1'b1;
    end
    if (valid_n) begin
      lost_n = 1'b0;
    end else if (gap == G_TOP && !rise) begin
      lost_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_LOW;
      presc <= '0;
      width <= '0;
      gap   <= '0;
      pend  <= 1'b0;
      pos   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      lost  <= 1'b1;
    end else begin
      state <= state_n;
      presc <= presc_n;
      width <= width_n;
      gap   <= gap_n;
      pend  <= pend_n;
      pos   <= pos_n;
      valid <= valid_n;
      err   <= err_n;
      lost  <= lost_n;
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed testbench for servo_pulse_decoder.
// Uses a short tick (M=8) so full frames fit in a small cycle budget.
module tb_servo_pulse_decoder;

  localparam int unsigned M   = 8;
  localparam int unsigned OFF = 46;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       servo_in = 1'b0;
  logic [7:0] pos;
  logic       valid;
  logic       err;
  logic       lost;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both = 0;
  logic [7:0] vlog[$];

  servo_pulse_decoder #(
    .M           (M),
    .OFFSET      (OFF),
    .FRAME_TICKS (2048)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .servo_in (servo_in),
    .pos      (pos),
    .valid    (valid),
    .err      (err),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      vlog.push_back(pos);
    end
    if (err) ecnt++;
    if (valid && err) both++;
  end

  task automatic pulse(input int n);
    @(negedge clk);
    servo_in = 1'b1;
    repeat (n) @(negedge clk);
    servo_in = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    servo_in = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (pos !== 8'd0) begin
      errors++;
      $display("FAIL reset_pos got %0d want 0", pos);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", valid);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b want 0", err);
    end
    checks++;
    if (lost !== 1'b1) begin
      errors++;
      $display("FAIL reset_lost got %b want 1", lost);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_pulse;
    @(negedge clk);
    servo_in = 1'b1;
    repeat (OFF * M) @(negedge clk);
    servo_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || lost !== 1'b1) begin
      errors++;
      $display("FAIL early_valid got v=%b l=%b want v=0 l=1", valid, lost);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL latency_valid got v=%b e=%b want v=1 e=0", valid, err);
    end
    checks++;
    if (pos !== 8'd0) begin
      errors++;
      $display("FAIL first_pos got %0d want 0", pos);
    end
    checks++;
    if (lost !== 1'b0) begin
      errors++;
      $display("FAIL lost_clear got %b want 0", lost);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_strobe got %b want 0", valid);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_range;
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    pulse(301 * M);
    checks++;
    if (pos !== 8'd255 || vcnt - v0 != 1 || ecnt != e0) begin
      errors++;
      $display("FAIL pos_max got pos=%0d v=%0d e=%0d want 255 1 0",
               pos, vcnt - v0, ecnt - e0);
    end
    v0 = vcnt;
    pulse(174 * M);
    checks++;
    if (pos !== 8'd128 || vcnt - v0 != 1 || ecnt != e0) begin
      errors++;
      $display("FAIL pos_mid got pos=%0d v=%0d e=%0d want 128 1 0",
               pos, vcnt - v0, ecnt - e0);
    end
  endtask

  task automatic test_rounding;
    pulse(100 * M + M / 2 - 1);
    checks++;
    if (pos !== 8'd54) begin
      errors++;
      $display("FAIL round_down got %0d want 54", pos);
    end
    pulse(100 * M + M / 2);
    checks++;
    if (pos !== 8'd55) begin
      errors++;
      $display("FAIL round_up got %0d want 55", pos);
    end
  endtask

  task automatic test_errors;
    int lens[3];
    int v0;
    int e0;
    lens[0] = 45 * M;
    lens[1] = 302 * M;
    lens[2] = 600 * M;
    for (int i = 0; i < 3; i++) begin
      v0 = vcnt;
      e0 = ecnt;
      pulse(lens[i]);
      checks++;
      if (ecnt - e0 != 1 || vcnt != v0 || pos !== 8'd55) begin
        errors++;
        $display("FAIL range_err%0d got e=%0d v=%0d pos=%0d want 1 0 55",
                 i, ecnt - e0, vcnt - v0, pos);
      end
    end
  endtask

  task automatic test_lost;
    int v0;
    pulse(100 * M + M / 2);
    repeat (2000 * M) @(negedge clk);
    checks++;
    if (lost !== 1'b0) begin
      errors++;
      $display("FAIL lost_early got %b want 0", lost);
    end
    repeat (48 * M) @(negedge clk);
    checks++;
    if (lost !== 1'b1) begin
      errors++;
      $display("FAIL lost_set got %b want 1", lost);
    end
    v0 = vcnt;
    pulse(174 * M);
    checks++;
    if (pos !== 8'd128 || vcnt - v0 != 1 || lost !== 1'b0) begin
      errors++;
      $display("FAIL lost_recover got pos=%0d v=%0d l=%b want 128 1 0",
               pos, vcnt - v0, lost);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    @(negedge clk);
    servo_in = 1'b1;
    repeat (100 * M + M / 2) @(negedge clk);
    servo_in = 1'b0;
    @(negedge clk);
    servo_in = 1'b1;
    repeat (301 * M) @(negedge clk);
    servo_in = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (vcnt - v0 != 2 || ecnt != e0) begin
      errors++;
      $display("FAIL b2b_count got v=%0d e=%0d want 2 0",
               vcnt - v0, ecnt - e0);
    end else begin
      checks++;
      if (vlog[vlog.size() - 2] !== 8'd55 || pos !== 8'd255) begin
        errors++;
        $display("FAIL b2b_pos got %0d,%0d want 55,255",
                 vlog[vlog.size() - 2], pos);
      end
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    int e0;
    @(negedge clk);
    servo_in = 1'b1;
    repeat (100 * M) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (pos !== 8'd0 || valid !== 1'b0 || err !== 1'b0 || lost !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got pos=%0d v=%b e=%b l=%b want 0 0 0 1",
               pos, valid, err, lost);
    end
    v0 = vcnt;
    e0 = ecnt;
    repeat (100 * M) @(negedge clk);
    servo_in = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (vcnt != v0 || ecnt != e0) begin
      errors++;
      $display("FAIL mid_discard got v=%0d e=%0d want 0 0",
               vcnt - v0, ecnt - e0);
    end
  endtask

  task automatic test_high_through_reset;
    int v0;
    int e0;
    @(negedge clk);
    servo_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    v0 = vcnt;
    e0 = ecnt;
    repeat (100 * M) @(negedge clk);
    servo_in = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (vcnt != v0 || ecnt != e0 || pos !== 8'd0) begin
      errors++;
      $display("FAIL partial got v=%0d e=%0d pos=%0d want 0 0 0",
               vcnt - v0, ecnt - e0, pos);
    end
    pulse(174 * M);
    checks++;
    if (vcnt - v0 != 1 || pos !== 8'd128) begin
      errors++;
      $display("FAIL after_partial got v=%0d pos=%0d want 1 128",
               vcnt - v0, pos);
    end
  endtask

  initial begin
    test_reset();
    test_first_pulse();
    test_range();
    test_rounding();
    test_errors();
    test_lost();
    test_back_to_back();
    test_reset_mid();
    test_high_through_reset();
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL valid_err_overlap got %0d want 0", both);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
